// File: rtl/dmem_stall_pkg.sv
// Shared types and defaults for the data-memory miss stall controller.
package dmem_stall_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_FILL = 2'd3
    } dmem_stall_state_t;

    localparam int DMEM_TIMEOUT_DEFAULT = 255;
    localparam int DMEM_CNT_W_DEFAULT   = 32;

endpackage

// File: rtl/dmem_perf_cnt.sv
// Miss and stall-cycle performance counters; only built with DMEM_STALL_PERF_EN.
module dmem_perf_cnt
    import dmem_stall_pkg::*;
#(
    parameter int CNT_W = DMEM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_inc_i,
    input  logic             stall_inc_i,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    logic [CNT_W-1:0] miss_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Free-running wrap-around counters
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (miss_inc_i) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
            if (stall_inc_i) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign miss_cnt_o  = miss_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Data-cache miss stall controller: refill handshake plus pipeline enable/flush gating.
// Optional perf counters are built when DMEM_STALL_PERF_EN is defined.
module dmem_stall_ctrl
    import dmem_stall_pkg::*;
#(
    parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT,
    parameter int CNT_W   = DMEM_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemAccessM_i,
    input  logic             HitM_i,
    input  logic             mem_ack_i,
    input  logic             PCen_i,
    input  logic             Fen_i,
    input  logic             Frst_i,
    input  logic             Drst_i,
    output logic             mem_req_o,
    output logic             fill_we_o,
    output logic             PCen_o,
    output logic             Fen_o,
    output logic             Den_o,
    output logic             Een_o,
    output logic             Men_o,
    output logic             Frst_o,
    output logic             Drst_o,
    output logic             Wrst_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

    dmem_stall_state_t state_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic [WCNT_W-1:0] wait_cnt_d;
    logic              err_q;
    logic              pend_f_q;
    logic              pend_d_q;
    logic              miss_det_s;
    logic              busy_s;

    assign miss_det_s = (state_q == ST_IDLE) & MemAccessM_i & ~HitM_i;
    // Reset forces the not-busy view so enables pass through while rst is high
    assign busy_s     = ~rst & ((state_q != ST_IDLE) | miss_det_s);

    // Saturating increment of the WAIT cycle counter
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cnt_q == TIMEOUT_C) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
    end

    // Refill FSM with wait counter, sticky timeout and deferred flush flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            pend_f_q   <= 1'b0;
            pend_d_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_det_s) begin
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_q    <= ST_WAIT;
                    wait_cnt_q <= '0;
                end
                ST_WAIT: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (wait_cnt_d == TIMEOUT_C) begin
                        err_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            pend_f_q <= busy_s ? (pend_f_q | Frst_i) : 1'b0;
            pend_d_q <= busy_s ? (pend_d_q | Drst_i) : 1'b0;
        end
    end

    // Handshake strobes and pipeline enable/flush gating
    always_comb begin
        mem_req_o = ~rst & ((state_q == ST_REQ) | ((state_q == ST_WAIT) & ~mem_ack_i));
        fill_we_o = ~rst & (state_q == ST_FILL);
        PCen_o    = 1'b0;
        Fen_o     = 1'b0;
        Den_o     = 1'b0;
        Een_o     = 1'b0;
        Men_o     = 1'b0;
        Wrst_o    = 1'b1;
        Frst_o    = 1'b0;
        Drst_o    = 1'b0;
        if (busy_s) begin
            Wrst_o = 1'b1;
        end else begin
            PCen_o = PCen_i;
            Fen_o  = Fen_i;
            Den_o  = Fen_i;
            Een_o  = 1'b1;
            Men_o  = 1'b1;
            Wrst_o = 1'b0;
            Frst_o = Frst_i | pend_f_q;
            Drst_o = Drst_i | pend_d_q;
        end
    end

    assign busy_o = busy_s;
    assign err_o  = err_q;

`ifdef DMEM_STALL_PERF_EN
    logic miss_inc_s;
    assign miss_inc_s = ~rst & miss_det_s;

    dmem_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .miss_inc_i (miss_inc_s),
        .stall_inc_i(busy_s),
        .miss_cnt_o (miss_cnt_o),
        .stall_cnt_o(stall_cnt_o)
    );
`else
    assign miss_cnt_o  = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Randomized scoreboard bench for dmem_stall_ctrl: the driver expands each
// hit/miss transaction into per-cycle expectations, a negedge monitor compares.
module tb_dmem_stall_ctrl;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_i = 1'b0, hit_i = 1'b0, ack_i = 1'b0;
    logic        pcen_i = 1'b0, fen_i = 1'b0, frst_i = 1'b0, drst_i = 1'b0;
    logic        mem_req, fill_we, pcen, fen, den, een, men, frst, drst, wrst, busy, err;
    logic [31:0] miss_cnt, stall_cnt;

    dmem_stall_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .MemAccessM_i(acc_i), .HitM_i(hit_i), .mem_ack_i(ack_i),
        .PCen_i(pcen_i), .Fen_i(fen_i), .Frst_i(frst_i), .Drst_i(drst_i),
        .mem_req_o(mem_req), .fill_we_o(fill_we),
        .PCen_o(pcen), .Fen_o(fen), .Den_o(den), .Een_o(een), .Men_o(men),
        .Frst_o(frst), .Drst_o(drst), .Wrst_o(wrst),
        .busy_o(busy), .err_o(err),
        .miss_cnt_o(miss_cnt), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] ctl;   // busy,mem_req,fill_we,PCen,Fen,Den,Een,Men,Frst,Drst,Wrst,err
        logic [31:0] mc;
        logic [31:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // reference state: deferred flushes, sticky error, perf totals
    logic        pend_f = 1'b0, pend_d = 1'b0, err_m = 1'b0;
    logic [31:0] miss_m = 32'd0, stall_m = 32'd0;
    int          flush_mode = 0;   // 0 random, 1 force flush, 2 force no flush

    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] act;
        cyc++;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {busy, mem_req, fill_we, pcen, fen, den, een, men, frst, drst, wrst, err};
            n_checks++;
            if (act !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d got=%b exp=%b", cyc, act, e.ctl);
            end
            n_checks++;
            if (miss_cnt !== e.mc) begin
                n_fail++;
                $display("FAIL miss_cnt cyc=%0d got=%0d exp=%0d", cyc, miss_cnt, e.mc);
            end
            n_checks++;
            if (stall_cnt !== e.sc) begin
                n_fail++;
                $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, e.sc);
            end
        end
    end

    // One clock of stimulus; busy_e/req_e/fill_e come from the transaction schedule.
    task automatic step(input logic acc, input logic hit, input logic ack, input logic r,
                        input logic busy_e, input logic req_e, input logic fill_e,
                        input logic det_e, input logic errset_e);
        exp_t e;
        logic pi, fi, fr, dr;
        @(posedge clk);
        #1;
        pi = 1'($urandom);
        fi = 1'($urandom);
        case (flush_mode)
            1:       begin fr = 1'b1; dr = 1'b1; end
            2:       begin fr = 1'b0; dr = 1'b0; end
            default: begin fr = 1'($urandom); dr = 1'($urandom); end
        endcase
        rst = r; acc_i = acc; hit_i = hit; ack_i = ack;
        pcen_i = pi; fen_i = fi; frst_i = fr; drst_i = dr;
        if (busy_e) begin
            e.ctl  = {1'b1, req_e, fill_e, 5'b00000, 2'b00, 1'b1, err_m};
            pend_f = pend_f | fr;
            pend_d = pend_d | dr;
        end else begin
            e.ctl  = {1'b0, req_e, fill_e, pi, fi, fi, 1'b1, 1'b1, fr | pend_f, dr | pend_d, 1'b0, err_m};
            pend_f = 1'b0;
            pend_d = 1'b0;
        end
`ifdef DMEM_STALL_PERF_EN
        e.mc = miss_m;
        e.sc = stall_m;
`else
        e.mc = 32'd0;
        e.sc = 32'd0;
`endif
        exp_q.push_back(e);
        if (r) begin
            err_m = 1'b0; miss_m = 32'd0; stall_m = 32'd0;
        end else begin
            if (errset_e) err_m = 1'b1;
            if (busy_e)   stall_m = stall_m + 32'd1;
            if (det_e)    miss_m  = miss_m + 32'd1;
        end
    endtask

    task automatic hits(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic resets(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Miss with n WAIT cycles (ack on the last). rst_at>0 resets at that WAIT cycle.
    // dir forces flushes only during WAIT.
    task automatic miss(input int n, input int rst_at, input logic dir);
        if (dir) flush_mode = 2;
        step(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= n; i++) begin
            if (i == rst_at) begin
                step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                flush_mode = 0;
                return;
            end
            if (dir) flush_mode = 1;
            step(1'b1, 1'b0, (i == n), 1'b0, 1'b1, (i != n), 1'b0, 1'b0, (i >= TO));
            if (dir) flush_mode = 2;
        end
        step(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        flush_mode = 0;
    endtask

    task automatic random_mix(input int k);
        for (int t = 0; t < k; t++) begin
            case ($urandom_range(0, 2))
                0:       hits($urandom_range(1, 3));
                1:       miss($urandom_range(1, 8), 0, 1'b0);
                default: begin
                    miss($urandom_range(1, 8), 0, 1'b0);
                    miss($urandom_range(1, 4), 0, 1'b0);
                end
            endcase
        end
    endtask

    initial begin
        @(posedge clk);
        resets(2);
        hits(6);
        miss(5, 0, 1'b1);
        flush_mode = 2;
        hits(2);
        flush_mode = 0;
        random_mix(15);
        miss(TO + 5, 0, 1'b0);
        hits(3);
        resets(1);
        hits(2);
        miss(8, 3, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        hits(3);
        random_mix(10);
        @(posedge clk);
        #1;
        acc_i = 1'b0;
        ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain leftover=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
